// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one ALU datapath between two requesters. The winner's operands are
//   latched onto alu_a/alu_b, the arbiter waits LAT cycles for the ALU, then
//   captures alu_y/alu_cout into y_out/cout_out and pulses done for one cycle.
//   Every output is registered. There is no combinational path from req to gnt.
//
//   Optional build macro: ALU_ARB_FIXED_PRIO_EN
//     defined   : requester 0 always wins a tie (last is tracked, not used)
//     undefined : round-robin on ties, the requester that was not served last wins
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req0, a0, b0       requester 0 request and operands (sampled at grant)
//   req1, a1, b1       requester 1 request and operands (sampled at grant)
//   gnt0, gnt1         ownership of the ALU (busy and done cycles)
//   sel                operand-mux select, 0 = requester 0, 1 = requester 1
//   alu_a, alu_b       latched operands driven to the ALU
//   alu_y, alu_cout    ALU result and carry-out
//   done0, done1       one-cycle pulse, y_out/cout_out valid for that requester
//   y_out, cout_out    captured result and carry, held until the next capture
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int WIDTH = 4,
   parameter int LAT   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_cout,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] y_out,
   output logic             cout_out
);

   localparam int CW = $clog2(LAT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             last, last_nx;
   logic             gnt0_nx, gnt1_nx, sel_nx, done0_nx, done1_nx, cout_nx;
   logic [WIDTH-1:0] alu_a_nx, alu_b_nx, y_nx;
   logic             win;
   logic             req_w;

   // Winner of an arbitration, meaningful only when req0 | req1.
`ifdef ALU_ARB_FIXED_PRIO_EN
   assign win = ~req0;
`else
   assign win = (req0 & req1) ? ~last : req1;
`endif

   // sel holds the current owner for the whole busy/done period.
   assign req_w = sel ? req1 : req0;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      last_nx  = last;
      gnt0_nx  = gnt0;
      gnt1_nx  = gnt1;
      sel_nx   = sel;
      alu_a_nx = alu_a;
      alu_b_nx = alu_b;
      done0_nx = 1'b0;
      done1_nx = 1'b0;
      y_nx     = y_out;
      cout_nx  = cout_out;
      case (state)
         IDLE: begin
            if (req0 | req1) begin
               state_nx = BUSY;
               sel_nx   = win;
               gnt0_nx  = ~win;
               gnt1_nx  = win;
               alu_a_nx = win ? a1 : a0;
               alu_b_nx = win ? b1 : b0;
               cnt_nx   = '0;
            end
         end
         BUSY: begin
            // Abort takes precedence over a completion on the same edge.
            if (!req_w) begin
               state_nx = IDLE;
               gnt0_nx  = 1'b0;
               gnt1_nx  = 1'b0;
            end else if (cnt == CNT_LAST) begin
               state_nx = DONE;
               y_nx     = alu_y;
               cout_nx  = alu_cout;
               done0_nx = ~sel;
               done1_nx = sel;
               last_nx  = sel;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
            gnt0_nx  = 1'b0;
            gnt1_nx  = 1'b0;
         end
         default: begin
            state_nx = IDLE;
            gnt0_nx  = 1'b0;
            gnt1_nx  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         last     <= 1'b1;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         sel      <= 1'b0;
         alu_a    <= '0;
         alu_b    <= '0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         y_out    <= '0;
         cout_out <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         last     <= last_nx;
         gnt0     <= gnt0_nx;
         gnt1     <= gnt1_nx;
         sel      <= sel_nx;
         alu_a    <= alu_a_nx;
         alu_b    <= alu_b_nx;
         done0    <= done0_nx;
         done1    <= done1_nx;
         y_out    <= y_nx;
         cout_out <= cout_nx;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Directed scenarios followed by randomized traffic for alu_share_arbiter,
//   with an adder standing in for the ALU and a transaction-level reference
//   model of the arbiter. Build with ALU_ARB_FIXED_PRIO_EN to check the
//   fixed-priority variant.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

   localparam int WIDTH = 4;
   localparam int LAT   = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req0 = 1'b0, req1 = 1'b0;
   logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic             gnt0, gnt1, sel, done0, done1, cout_out, alu_cout;
   logic [WIDTH-1:0] alu_a, alu_b, alu_y, y_out;

   int checks = 0;
   int errors = 0;

   // Reference model state: owner is -1 when idle, elapsed counts busy edges.
   int               m_owner;
   int               m_elapsed;
   bit               m_done_cyc;
   bit               m_last;
   logic             e_gnt0, e_gnt1, e_sel, e_done0, e_done1, e_cout;
   logic [WIDTH-1:0] e_a, e_b, e_y;

   always #5 clk = ~clk;

   assign {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};

   alu_share_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_cout(alu_cout),
      .done0(done0), .done1(done1), .y_out(y_out), .cout_out(cout_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_elapsed = 0; m_done_cyc = 1'b0; m_last = 1'b1;
      e_gnt0 = 0; e_gnt1 = 0; e_sel = 0; e_done0 = 0; e_done1 = 0;
      e_a = '0; e_b = '0; e_y = '0; e_cout = 0;
   endtask

   // One clock edge of the arbiter, seen as transactions: grant, LAT busy
   // edges, one done cycle; a dropped request while busy cancels the job.
   task automatic model_step();
      int w;
      bit r;
      logic [WIDTH:0] sum;
      if (m_done_cyc) begin
         e_done0 = 0; e_done1 = 0; e_gnt0 = 0; e_gnt1 = 0;
         m_owner = -1; m_done_cyc = 0;
      end else if (m_owner < 0) begin
         if (req0 || req1) begin
            if (req0 && req1) w = FIXED ? 0 : (m_last ? 0 : 1);
            else              w = req0 ? 0 : 1;
            m_owner = w; m_elapsed = 0;
            e_sel = (w == 1);
            e_gnt0 = (w == 0); e_gnt1 = (w == 1);
            e_a = (w == 1) ? a1 : a0;
            e_b = (w == 1) ? b1 : b0;
         end
      end else begin
         r = (m_owner == 0) ? req0 : req1;
         if (!r) begin
            e_gnt0 = 0; e_gnt1 = 0; m_owner = -1;
         end else begin
            m_elapsed++;
            if (m_elapsed == LAT) begin
               sum = {1'b0, e_a} + {1'b0, e_b};
               e_y = sum[WIDTH-1:0];
               e_cout = sum[WIDTH];
               e_done0 = (m_owner == 0); e_done1 = (m_owner == 1);
               m_last = (m_owner == 1);
               m_done_cyc = 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("gnt0", gnt0, e_gnt0);
      check("gnt1", gnt1, e_gnt1);
      check("sel", sel, e_sel);
      check("alu_a", alu_a, e_a);
      check("alu_b", alu_b, e_b);
      check("done0", done0, e_done0);
      check("done1", done1, e_done1);
      check("y_out", y_out, e_y);
      check("cout_out", cout_out, e_cout);
      check("gnt_exclusive", gnt0 & gnt1, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic wait_done(input int who, input string tag);
      bit seen = 0;
      for (int i = 0; i < LAT + 4 && !seen; i++) begin
         tick();
         if (((who == 0) ? done0 : done1) === 1'b1) seen = 1;
      end
      check(tag, seen, 1'b1);
   endtask

   initial begin
      int grants[$];
      int pg0, pg1;
      model_reset();

      // Reset state
      tick(); tick();
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_y_out", y_out, '0);
      rst_n = 1'b1;
      tick();

      // Single request from 0, operands disturbed after grant
      a0 = 4'd3; b0 = 4'd5; req0 = 1;
      tick();
      check("t2_gnt0", gnt0, 1'b1);
      check("t2_sel", sel, 1'b0);
      check("t2_alu_a", alu_a, 4'd3);
      check("t2_alu_b", alu_b, 4'd5);
      a0 = 4'd15; b0 = 4'd15;
      wait_done(0, "t2_done0_seen");
      check("t2_y", y_out, 4'd8);
      check("t2_cout", cout_out, 1'b0);
      check("t6_alu_a_held", alu_a, 4'd3);
      req0 = 0;
      tick();

      // Single request from 1 with carry
      a1 = 4'd9; b1 = 4'd9; req1 = 1;
      tick();
      check("t3_sel", sel, 1'b1);
      wait_done(1, "t3_done1_seen");
      check("t3_y", y_out, 4'd2);
      check("t3_cout", cout_out, 1'b1);
      req1 = 0;
      tick();

      // Both held high: record the order of grants
      req0 = 1; req1 = 1;
      pg0 = 0; pg1 = 0;
      for (int i = 0; i < 60 && grants.size() < 4; i++) begin
         tick();
         if (gnt0 === 1'b1 && pg0 == 0) grants.push_back(0);
         if (gnt1 === 1'b1 && pg1 == 0) grants.push_back(1);
         pg0 = (gnt0 === 1'b1); pg1 = (gnt1 === 1'b1);
      end
      check("t4_grant_count", grants.size(), 4);
      if (grants.size() == 4) begin
         wait_done(grants[3], "t4_last_done_seen");
         for (int i = 0; i < 4; i++)
            check("t4_grant_order", grants[i], FIXED ? 0 : (i % 2));
      end
      req0 = 0; req1 = 0;
      tick();

      // Abort: requester 0 completes, requester 1 aborts, then a tie
      a0 = 4'd1; b0 = 4'd2; req0 = 1;
      tick();
      wait_done(0, "t5_done0_seen");
      req0 = 0;
      tick();
      a1 = 4'd7; b1 = 4'd7; req1 = 1;
      tick();
      tick();
      req1 = 0;
      tick();
      check("t5_gnt1_dropped", gnt1, 1'b0);
      check("t5_no_done1", done1, 1'b0);
      check("t5_y_kept", y_out, 4'd3);
      tick(); tick();
      check("t5_y_still_kept", y_out, 4'd3);
      req0 = 1; req1 = 1;
      tick();
      check("t5_tie_gnt1", gnt1, FIXED ? 1'b0 : 1'b1);
      wait_done(FIXED ? 0 : 1, "t5_tie_done_seen");
      req0 = 0; req1 = 0;
      tick();

      // Reset in the middle of a busy period
      a0 = 4'd4; b0 = 4'd4; req0 = 1;
      tick(); tick();
      rst_n = 0;
      #1;
      model_reset();
      compare_all();
      check("t1_gnt0_async", gnt0, 1'b0);
      check("t1_alu_a_async", alu_a, '0);
      tick();
      req0 = 0; rst_n = 1;
      for (int i = 0; i < LAT + 3; i++) begin
         tick();
         check("t1_no_done0", done0, 1'b0);
      end

      // Randomized traffic with aborts, re-requests and occasional resets
      for (int c = 0; c < 1500; c++) begin
         if (!req0) begin
            if ($urandom_range(2) == 0) begin req0 = 1; a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); end
         end else if (e_done0 && $urandom_range(3) != 0) req0 = 0;
         else if (e_gnt0 && $urandom_range(15) == 0) req0 = 0;
         if (!req1) begin
            if ($urandom_range(2) == 0) begin req1 = 1; a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); end
         end else if (e_done1 && $urandom_range(3) != 0) req1 = 0;
         else if (e_gnt1 && $urandom_range(15) == 0) req1 = 0;
         if ($urandom_range(1) == 0) begin a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); end
         if ($urandom_range(1) == 0) begin a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); end
         if ($urandom_range(299) == 0) begin
            rst_n = 0;
            #1;
            model_reset();
            compare_all();
            tick();
            rst_n = 1;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
